// File: rtl/axis_frame_pkg.sv
// -----------------------------------------------------------------------------
// axis_frame_pkg
// Shared definitions for the AXI-Stream frame source: FSM state encoding,
// last-beat keep-mask helper and beat-count helper.
// No ports (package).
// -----------------------------------------------------------------------------
package axis_frame_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Byte-enable mask for the last beat. A remainder of zero means the last
  // beat is full, so every lane is enabled.
  function automatic logic [63:0] keep_mask(input int unsigned rem,
                                            input int unsigned kw);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < kw && (rem == 0 || i < rem)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Number of beats needed to carry len bytes at kw bytes per beat.
  function automatic int unsigned beats_from_len(input int unsigned len,
                                                 input int unsigned kw);
    return (len + kw - 1) / kw;
  endfunction

endpackage

// File: rtl/axis_frame_source_if.sv
// -----------------------------------------------------------------------------
// axis_frame_source_if
// AXI-Stream bundle used by the frame source.
//   tdata  DATA_WIDTH  payload
//   tkeep  KEEP_WIDTH  byte enables
//   tvalid 1           beat valid
//   tready 1           sink ready
//   tlast  1           last beat of frame
//   tuser  1           frame error flag
// master: stream driver, slave: stream sink.
// -----------------------------------------------------------------------------
interface axis_frame_source_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_source.sv
// -----------------------------------------------------------------------------
// axis_frame_source
// Emits one AXI-Stream frame per start command: cfg_len bytes of an
// incrementing-byte payload beginning at cfg_seed, with optional error flag
// on tuser of the last beat. Honours tready backpressure.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   async active-low reset
//   cfg_start  in   single-cycle start request
//   cfg_len    in   frame length in bytes (0 = ignored)
//   cfg_seed   in   first payload byte
//   cfg_err    in   flag frame as bad on last beat
//   busy       out  frame in progress
//   done       out  one-cycle pulse after last beat accepted
//   frame_cnt  out  completed frame count (wraps)
//   m_axis     master stream port
//
// States:
//   ST_IDLE | waiting for cfg_start with nonzero length
//   ST_SEND | presenting beats, advancing on each tvalid&tready
// -----------------------------------------------------------------------------
module axis_frame_source
  import axis_frame_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_ENABLE = 1,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [7:0]           cfg_seed,
  input  logic                 cfg_err,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          frame_cnt,
  axis_frame_source_if.master  m_axis
);

  state_e                  state_q;
  logic [LEN_WIDTH-1:0]    beats_left_q;   // beats not yet loaded into the output regs
  logic [7:0]              base_q;         // lane-0 byte of the next beat to load
  logic                    err_q;
  logic [KEEP_WIDTH-1:0]   last_keep_q;
  logic [DATA_WIDTH-1:0]   tdata_q;
  logic [KEEP_WIDTH-1:0]   tkeep_q;
  logic                    tvalid_q;
  logic                    tlast_q;
  logic                    tuser_q;
  logic                    busy_q;
  logic                    done_q;
  logic [15:0]             frame_cnt_q;

  logic [LEN_WIDTH-1:0]    start_beats;
  logic [KEEP_WIDTH-1:0]   start_mask;
  logic [7:0]              base_d;
  logic                    last_d;
  logic                    err_d;
  logic [KEEP_WIDTH-1:0]   mask_d;
  logic [DATA_WIDTH-1:0]   beat_data_d;
  logic [KEEP_WIDTH-1:0]   beat_keep_d;

  assign start_beats = LEN_WIDTH'(beats_from_len(32'(cfg_len), KEEP_WIDTH));
  assign start_mask  = KEEP_WIDTH'(keep_mask(32'(cfg_len) % KEEP_WIDTH, KEEP_WIDTH));

  // Describes the beat that will be loaded on the next edge: the first beat
  // when starting from idle, otherwise the following beat of the frame.
  always_comb begin
    base_d = base_q;
    last_d = (beats_left_q == LEN_WIDTH'(1));
    err_d  = err_q;
    mask_d = last_keep_q;
    if (state_q == ST_IDLE) begin
      base_d = cfg_seed;
      last_d = (start_beats == LEN_WIDTH'(1));
      err_d  = cfg_err;
      mask_d = start_mask;
    end
  end

  // Payload lanes; disabled lanes of the last beat are zeroed even when tkeep
  // itself is tied to all ones.
  for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane
    assign beat_data_d[8*i +: 8] = (last_d && !mask_d[i]) ? 8'h00 : base_d + 8'(i);
  end

  assign beat_keep_d = (KEEP_ENABLE != 0 && last_d) ? mask_d : '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      base_q       <= '0;
      err_q        <= 1'b0;
      last_keep_q  <= '0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_start && cfg_len != '0) begin
            err_q        <= cfg_err;
            last_keep_q  <= start_mask;
            beats_left_q <= start_beats - LEN_WIDTH'(1);
            base_q       <= base_d + 8'(KEEP_WIDTH);
            tdata_q      <= beat_data_d;
            tkeep_q      <= beat_keep_d;
            tlast_q      <= last_d;
            tuser_q      <= err_d && last_d;
            tvalid_q     <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m_axis.tready) begin
            if (tlast_q) begin
              tdata_q     <= '0;
              tkeep_q     <= '0;
              tlast_q     <= 1'b0;
              tuser_q     <= 1'b0;
              tvalid_q    <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              state_q     <= ST_IDLE;
            end else begin
              beats_left_q <= beats_left_q - LEN_WIDTH'(1);
              base_q       <= base_d + 8'(KEEP_WIDTH);
              tdata_q      <= beat_data_d;
              tkeep_q      <= beat_keep_d;
              tlast_q      <= last_d;
              tuser_q      <= err_d && last_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = tkeep_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_source
// Directed bench for axis_frame_source (32-bit data, 4 lanes).
// -----------------------------------------------------------------------------
module tb_axis_frame_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [7:0]  cfg_seed = '0;
  logic        cfg_err = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;

  axis_frame_source_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) m_axis ();

  axis_frame_source #(
    .DATA_WIDTH (32),
    .KEEP_ENABLE(1),
    .KEEP_WIDTH (4),
    .LEN_WIDTH  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_start(cfg_start),
    .cfg_len  (cfg_len),
    .cfg_seed (cfg_seed),
    .cfg_err  (cfg_err),
    .busy     (busy),
    .done     (done),
    .frame_cnt(frame_cnt),
    .m_axis   (m_axis)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = '0;

  logic [31:0] cap_data [0:15];
  logic [3:0]  cap_keep [0:15];
  logic        cap_last [0:15];
  logic        cap_user [0:15];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int seed, input int k, input int len);
    int beats = (len + 3) / 4;
    int rem = len % 4;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      if (k == beats - 1 && rem != 0 && i >= rem) d[8*i +: 8] = 8'h00;
      else d[8*i +: 8] = 8'((seed + k * 4 + i) & 255);
    end
    return d;
  endfunction

  function automatic logic [3:0] exp_keep(input int k, input int len);
    int beats = (len + 3) / 4;
    int rem = len % 4;
    if (k == beats - 1 && rem != 0) return 4'((1 << rem) - 1);
    return 4'hF;
  endfunction

  // Asserts start at the current negedge, returns at the next one.
  task automatic start_frame(input int len, input int seed, input bit err);
    cfg_start = 1'b1;
    cfg_len   = 16'(len);
    cfg_seed  = 8'(seed);
    cfg_err   = err;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // Consumes one frame; stall=1 drives tready 1,0,0,1,0,0,...
  task automatic recv(input int len, input int seed, input bit err, input bit stall);
    int beats = (len + 3) / 4;
    int k = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [31:0] pd;
    logic [3:0]  pk;
    logic        pl, pu;
    while (k < beats && cyc < 400) begin
      m_axis.tready = stall ? (cyc % 3 == 0) : 1'b1;
      chk("tvalid", m_axis.tvalid, 1);
      chk("busy", busy, 1);
      chk("done_mid", done, 0);
      if (held) begin
        chk("hold_data", m_axis.tdata, pd);
        chk("hold_keep", m_axis.tkeep, pk);
        chk("hold_last", m_axis.tlast, pl);
        chk("hold_user", m_axis.tuser, pu);
      end
      if (m_axis.tready) begin
        chk("data", m_axis.tdata, exp_data(seed, k, len));
        chk("keep", m_axis.tkeep, exp_keep(k, len));
        chk("last", m_axis.tlast, (k == beats - 1));
        chk("user", m_axis.tuser, (err && k == beats - 1));
        if (k < 16) begin
          cap_data[k] = m_axis.tdata;
          cap_keep[k] = m_axis.tkeep;
          cap_last[k] = m_axis.tlast;
          cap_user[k] = m_axis.tuser;
        end
        k++;
        held = 1'b0;
      end else begin
        pd = m_axis.tdata;
        pk = m_axis.tkeep;
        pl = m_axis.tlast;
        pu = m_axis.tuser;
        held = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (k < beats) chk("timeout", 0, 1);
    exp_cnt = exp_cnt + 16'd1;
    chk("done", done, 1);
    chk("end_valid", m_axis.tvalid, 0);
    chk("end_busy", busy, 0);
    chk("frame_cnt", frame_cnt, exp_cnt);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_valid", m_axis.tvalid, 0);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    m_axis.tready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", m_axis.tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_data", m_axis.tdata, 0);
    chk("rst_keep", m_axis.tkeep, 0);
    chk("rst_last", m_axis.tlast, 0);
    chk("rst_user", m_axis.tuser, 0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_cnt = '0;

    // len=8 seed=0x10
    start_frame(8, 'h10, 1'b0);
    recv(8, 'h10, 1'b0, 1'b0);
    chk("t1_b0", cap_data[0], 32'h13121110);
    chk("t1_b1", cap_data[1], 32'h17161514);
    chk("t1_k1", cap_keep[1], 4'hF);
    chk("t1_l0", cap_last[0], 0);
    chk("t1_cnt", frame_cnt, 16'd1);
    idle_cycles(1);

    // len=6 seed=0xFE err=1
    start_frame(6, 'hFE, 1'b1);
    recv(6, 'hFE, 1'b1, 1'b0);
    chk("t2_b0", cap_data[0], 32'h0100FFFE);
    chk("t2_k0", cap_keep[0], 4'hF);
    chk("t2_u0", cap_user[0], 0);
    chk("t2_b1", cap_data[1], 32'h00000302);
    chk("t2_k1", cap_keep[1], 4'h3);
    chk("t2_l1", cap_last[1], 1);
    chk("t2_u1", cap_user[1], 1);
    idle_cycles(1);

    // len=16 with backpressure
    start_frame(16, 'h30, 1'b0);
    recv(16, 'h30, 1'b0, 1'b1);
    chk("t3_b3", cap_data[3], 32'h3F3E3D3C);
    idle_cycles(1);

    // zero length ignored; start during busy ignored
    m_axis.tready = 1'b1;
    start_frame(0, 'h55, 1'b1);
    idle_cycles(3);
    m_axis.tready = 1'b0;
    start_frame(8, 'h40, 1'b0);
    start_frame(4, 'h99, 1'b1);
    chk("t4_hold", m_axis.tdata, 32'h43424140);
    recv(8, 'h40, 1'b0, 1'b0);
    idle_cycles(3);
    chk("t4_cnt", frame_cnt, 16'd4);

    // reset mid-frame
    m_axis.tready = 1'b1;
    start_frame(16, 'h20, 1'b0);
    @(negedge clk);
    chk("t5_b1", m_axis.tdata, 32'h27262524);
    rst_n = 1'b0;
    #1;
    chk("t5_valid", m_axis.tvalid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cnt", frame_cnt, 0);
    chk("t5_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    idle_cycles(2);
    start_frame(16, 'h77, 1'b0);
    recv(16, 'h77, 1'b0, 1'b0);
    chk("t5_b0", cap_data[0], 32'h7A797877);
    idle_cycles(1);

    // back-to-back frames, start on the done cycle
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_cnt = '0;
    for (int f = 0; f < 200; f++) begin
      start_frame(5, (f * 7) & 255, 1'b0);
      recv(5, (f * 7) & 255, 1'b0, 1'b0);
      chk("b2b_keep1", cap_keep[1], 4'h1);
    end
    chk("b2b_cnt", frame_cnt, 16'd200);
    idle_cycles(1);

    // counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    chk("wrap_pre", frame_cnt, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    start_frame(3, 'hA0, 1'b0);
    recv(3, 'hA0, 1'b0, 1'b0);
    chk("wrap_zero", frame_cnt, 16'h0000);
    chk("wrap_data", cap_data[0], 32'h00A2A1A0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
